// File: rtl/volume_ramp.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | volume_ramp : per-channel gain stage for a TDM stream; gains ramp toward   |
// |               their targets one step per processed sample.                 |
// | Revision 1.0                                                               |
// +----------------------------------------------------------------------------+
module volume_ramp #(
   parameter int NR_CHANNELS = 3,
   parameter int INPUT_WIDTH = 24,
   parameter int GAIN_WIDTH  = 16,
   parameter int RAMP_STEP   = 64,
   localparam int CHANNEL_WIDTH = $clog2(NR_CHANNELS)
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [INPUT_WIDTH-1:0]   s_tdata,
   input  logic [CHANNEL_WIDTH-1:0] s_tid,
   input  logic                     s_tvalid,
   output logic                     s_tready,
   output logic [INPUT_WIDTH-1:0]   m_tdata,
   output logic [CHANNEL_WIDTH-1:0] m_tid,
   output logic                     m_tvalid,
   input  logic                     m_tready,
   input  logic [GAIN_WIDTH-1:0]    gain_value,
   input  logic [CHANNEL_WIDTH-1:0] gain_ch,
   input  logic                     gain_valid,
   input  logic                     mute,
   output logic                     ramp_busy,
   output logic                     overflow
);

   localparam logic [GAIN_WIDTH-1:0]  C_UNITY    = {1'b1, {(GAIN_WIDTH-1){1'b0}}};
   localparam logic [GAIN_WIDTH-1:0]  C_STEP     = GAIN_WIDTH'(RAMP_STEP);
   localparam int                     PROD_WIDTH = INPUT_WIDTH + GAIN_WIDTH + 1;
   localparam logic [INPUT_WIDTH-1:0] C_SAT_MAX  = {1'b0, {(INPUT_WIDTH-1){1'b1}}};
   localparam logic [INPUT_WIDTH-1:0] C_SAT_MIN  = {1'b1, {(INPUT_WIDTH-1){1'b0}}};

   logic [GAIN_WIDTH-1:0]    target_q  [NR_CHANNELS];
   logic [GAIN_WIDTH-1:0]    target_d  [NR_CHANNELS];
   logic [GAIN_WIDTH-1:0]    current_q [NR_CHANNELS];
   logic [GAIN_WIDTH-1:0]    current_d [NR_CHANNELS];
   logic [INPUT_WIDTH-1:0]   m_tdata_q,   m_tdata_d;
   logic [CHANNEL_WIDTH-1:0] m_tid_q,     m_tid_d;
   logic                     m_tvalid_q,  m_tvalid_d;
   logic                     overflow_q,  overflow_d;
   logic                     ramp_busy_q, ramp_busy_d;

   logic                          w_accept;
   logic                          w_tid_ok;
   logic [GAIN_WIDTH-1:0]         w_cur_sel;
   logic [GAIN_WIDTH-1:0]         w_eff_sel;
   logic signed [PROD_WIDTH-1:0]  w_prod;
   logic signed [PROD_WIDTH-1:0]  w_prod_shr;
   logic [PROD_WIDTH-INPUT_WIDTH:0] w_upper;
   logic                          w_sat;
   logic [INPUT_WIDTH-1:0]        w_scaled;

   function automatic logic [GAIN_WIDTH-1:0] ramp_toward(
      input logic [GAIN_WIDTH-1:0] cur,
      input logic [GAIN_WIDTH-1:0] eff
   );
      if (cur < eff) begin
         return ((eff - cur) > C_STEP) ? (cur + C_STEP) : eff;
      end else if (cur > eff) begin
         return ((cur - eff) > C_STEP) ? (cur - C_STEP) : eff;
      end
      return cur;
   endfunction

   assign s_tready  = !m_tvalid_q || m_tready;
   assign w_accept  = s_tvalid && s_tready;
   assign m_tdata   = m_tdata_q;
   assign m_tid     = m_tid_q;
   assign m_tvalid  = m_tvalid_q;
   assign overflow  = overflow_q;
   assign ramp_busy = ramp_busy_q;

   always_comb begin
      w_tid_ok  = 1'b0;
      w_cur_sel = '0;
      w_eff_sel = '0;
      for (int c = 0; c < NR_CHANNELS; c++) begin
         if (s_tid == CHANNEL_WIDTH'(c)) begin
            w_tid_ok  = 1'b1;
            w_cur_sel = current_q[c];
            w_eff_sel = mute ? '0 : target_q[c];
         end
      end
   end

   // Gain is unsigned, so it gets a zero sign bit before the signed multiply.
   always_comb begin
      w_prod     = PROD_WIDTH'($signed(s_tdata)) * PROD_WIDTH'($signed({1'b0, w_cur_sel}));
      w_prod_shr = w_prod >>> (GAIN_WIDTH - 1);
      w_upper    = w_prod_shr[PROD_WIDTH-1:INPUT_WIDTH-1];
      w_sat      = (w_upper != '0) && (w_upper != '1);
      if (w_sat) begin
         w_scaled = w_prod_shr[PROD_WIDTH-1] ? C_SAT_MIN : C_SAT_MAX;
      end else begin
         w_scaled = w_prod_shr[INPUT_WIDTH-1:0];
      end
   end

   always_comb begin
      target_d    = target_q;
      current_d   = current_q;
      m_tdata_d   = m_tdata_q;
      m_tid_d     = m_tid_q;
      m_tvalid_d  = m_tvalid_q;
      overflow_d  = 1'b0;
      ramp_busy_d = 1'b0;

      if (w_accept) begin
         m_tvalid_d = 1'b1;
         m_tid_d    = s_tid;
         m_tdata_d  = w_tid_ok ? w_scaled : '0;
         overflow_d = w_tid_ok && w_sat;
         for (int c = 0; c < NR_CHANNELS; c++) begin
            if (s_tid == CHANNEL_WIDTH'(c)) begin
               current_d[c] = ramp_toward(w_cur_sel, w_eff_sel);
            end
         end
      end else if (m_tready) begin
         m_tvalid_d = 1'b0;
      end

      // The ramp above reads target_q, so a same-cycle write only affects later samples.
      if (gain_valid) begin
         for (int c = 0; c < NR_CHANNELS; c++) begin
            if (gain_ch == CHANNEL_WIDTH'(c)) begin
               target_d[c] = gain_value;
            end
         end
      end

      for (int c = 0; c < NR_CHANNELS; c++) begin
         if (current_d[c] != (mute ? '0 : target_d[c])) begin
            ramp_busy_d = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int c = 0; c < NR_CHANNELS; c++) begin
            target_q[c]  <= C_UNITY;
            current_q[c] <= '0;
         end
         m_tdata_q   <= '0;
         m_tid_q     <= '0;
         m_tvalid_q  <= 1'b0;
         overflow_q  <= 1'b0;
         ramp_busy_q <= 1'b0;
      end else begin
         target_q    <= target_d;
         current_q   <= current_d;
         m_tdata_q   <= m_tdata_d;
         m_tid_q     <= m_tid_d;
         m_tvalid_q  <= m_tvalid_d;
         overflow_q  <= overflow_d;
         ramp_busy_q <= ramp_busy_d;
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_volume_ramp.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_volume_ramp : directed self-checking bench for volume_ramp.             |
// | Revision 1.0                                                               |
// +----------------------------------------------------------------------------+
module tb_volume_ramp;

   logic               clk = 1'b0;
   logic               rst = 1'b1;
   logic signed [23:0] s_tdata = '0;
   logic [1:0]         s_tid = '0;
   logic               s_tvalid = 1'b0;
   logic               s_tready;
   logic signed [23:0] m_tdata;
   logic [1:0]         m_tid;
   logic               m_tvalid;
   logic               m_tready = 1'b1;
   logic [15:0]        gain_value = '0;
   logic [1:0]         gain_ch = '0;
   logic               gain_valid = 1'b0;
   logic               mute = 1'b0;
   logic               ramp_busy;
   logic               overflow;

   int n_checks = 0;
   int n_fail   = 0;
   logic [1:0] hs_q[$];

   volume_ramp #(
      .NR_CHANNELS(3),
      .INPUT_WIDTH(24),
      .GAIN_WIDTH (16),
      .RAMP_STEP  (64)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .s_tdata   (s_tdata),
      .s_tid     (s_tid),
      .s_tvalid  (s_tvalid),
      .s_tready  (s_tready),
      .m_tdata   (m_tdata),
      .m_tid     (m_tid),
      .m_tvalid  (m_tvalid),
      .m_tready  (m_tready),
      .gain_value(gain_value),
      .gain_ch   (gain_ch),
      .gain_valid(gain_valid),
      .mute      (mute),
      .ramp_busy (ramp_busy),
      .overflow  (overflow)
   );

   always #5 clk = ~clk;

   // Record every completed output transfer for ordering checks.
   always @(posedge clk) begin
      if (!rst && m_tvalid && m_tready) hs_q.push_back(m_tid);
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached, expected completion");
      $fatal(1, "watchdog");
   end

   // One accepted sample with m_tready high; outputs sampled 1 time unit after the edge.
   task automatic xfer(input logic [1:0] tid, input logic signed [23:0] din,
                       output logic signed [23:0] dout, output logic [1:0] oid, output logic ov);
      @(negedge clk);
      s_tvalid = 1'b1;
      s_tid    = tid;
      s_tdata  = din;
      @(posedge clk);
      #1;
      dout     = m_tdata;
      oid      = m_tid;
      ov       = overflow;
      s_tvalid = 1'b0;
   endtask

   task automatic test_reset();
      repeat (2) @(posedge clk);
      #1;
      n_checks++;
      if (m_tvalid !== 1'b0 || m_tdata !== 24'sd0 || m_tid !== 2'd0 || overflow !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_outputs: got valid=%0b data=%0d id=%0d ovf=%0b, expected all 0",
                  m_tvalid, m_tdata, m_tid, overflow);
      end
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk);
      #1;
      n_checks++;
      if (ramp_busy !== 1'b1) begin
         n_fail++;
         $display("FAIL reset_busy: got %0b, expected 1", ramp_busy);
      end
   endtask

   task automatic test_fade_in();
      logic signed [23:0] d;
      logic [1:0]         id;
      logic               ov;
      logic signed [23:0] exp_d;
      for (int n = 0; n < 512; n++) begin
         for (int c = 0; c < 3; c++) begin
            xfer(2'(c), 24'sd16384, d, id, ov);
            exp_d = 24'(32 * n);
            n_checks++;
            if (d !== exp_d || id !== 2'(c)) begin
               n_fail++;
               $display("FAIL fade_in n=%0d ch=%0d: got data=%0d id=%0d, expected data=%0d id=%0d",
                        n, c, d, id, exp_d, c);
            end
         end
      end
      n_checks++;
      if (ramp_busy !== 1'b0) begin
         n_fail++;
         $display("FAIL fade_in_busy: got %0b, expected 0", ramp_busy);
      end
      xfer(2'd0, 24'sd16384, d, id, ov);
      n_checks++;
      if (d !== 24'sd16384) begin
         n_fail++;
         $display("FAIL fade_in_settled: got %0d, expected 16384", d);
      end
   endtask

   task automatic test_overflow();
      logic signed [23:0] d;
      logic [1:0]         id;
      logic               ov;
      @(negedge clk);
      gain_valid = 1'b1;
      gain_ch    = 2'd1;
      gain_value = 16'hFFFF;
      @(posedge clk);
      #1;
      gain_valid = 1'b0;
      n_checks++;
      if (ramp_busy !== 1'b1) begin
         n_fail++;
         $display("FAIL ovf_busy_after_write: got %0b, expected 1", ramp_busy);
      end
      for (int i = 0; i < 512; i++) xfer(2'd1, 24'sd0, d, id, ov);
      n_checks++;
      if (ramp_busy !== 1'b0) begin
         n_fail++;
         $display("FAIL ovf_settle_busy: got %0b, expected 0", ramp_busy);
      end
      xfer(2'd1, 24'sd6291456, d, id, ov);
      n_checks++;
      if (d !== 24'sd8388607 || ov !== 1'b1) begin
         n_fail++;
         $display("FAIL ovf_pos: got data=%0d ovf=%0b, expected 8388607 ovf=1", d, ov);
      end
      xfer(2'd1, -24'sd6291456, d, id, ov);
      n_checks++;
      if (d !== -24'sd8388608 || ov !== 1'b1) begin
         n_fail++;
         $display("FAIL ovf_neg: got data=%0d ovf=%0b, expected -8388608 ovf=1", d, ov);
      end
      xfer(2'd1, 24'sd1000, d, id, ov);
      n_checks++;
      if (d !== 24'sd1999 || ov !== 1'b0) begin
         n_fail++;
         $display("FAIL ovf_none: got data=%0d ovf=%0b, expected 1999 ovf=0", d, ov);
      end
      @(posedge clk);
      #1;
      n_checks++;
      if (m_tvalid !== 1'b0 || overflow !== 1'b0) begin
         n_fail++;
         $display("FAIL ovf_idle: got valid=%0b ovf=%0b, expected 0 0", m_tvalid, overflow);
      end
   endtask

   task automatic test_mute();
      logic signed [23:0] d;
      logic [1:0]         id;
      logic               ov;
      logic signed [23:0] exp_d;
      longint             e;
      logic signed [23:0] tail_in  [5] = '{24'sd100000, 24'sd100000, 24'sd100000, 24'sd100000, 24'sd100000};
      logic signed [23:0] tail_exp [5] = '{24'sd0, 24'sd195, 24'sd390, 24'sd195, 24'sd0};
      logic               tail_mute[5] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
      mute = 1'b1;
      for (int k = 0; k <= 512; k++) begin
         xfer(2'd2, 24'sd100000, d, id, ov);
         e     = (longint'(100000) * longint'(32768 - 64 * k)) >>> 15;
         exp_d = 24'(e);
         n_checks++;
         if (d !== exp_d) begin
            n_fail++;
            $display("FAIL mute_ramp k=%0d: got %0d, expected %0d", k, d, exp_d);
         end
      end
      // Unmute ramps up from 0, then re-muting mid-ramp turns back without a jump.
      for (int i = 0; i < 5; i++) begin
         mute = tail_mute[i];
         xfer(2'd2, tail_in[i], d, id, ov);
         n_checks++;
         if (d !== tail_exp[i]) begin
            n_fail++;
            $display("FAIL mute_toggle i=%0d: got %0d, expected %0d", i, d, tail_exp[i]);
         end
      end
   endtask

   task automatic test_back_to_back();
      @(posedge clk);
      #1;
      hs_q.delete();
      @(negedge clk);
      m_tready = 1'b0;
      s_tvalid = 1'b1;
      s_tid    = 2'd0;
      s_tdata  = 24'sd5000;
      @(posedge clk);
      #1;
      n_checks++;
      if (m_tvalid !== 1'b1 || m_tdata !== 24'sd5000 || m_tid !== 2'd0) begin
         n_fail++;
         $display("FAIL bp_first: got valid=%0b data=%0d id=%0d, expected 1 5000 0", m_tvalid, m_tdata, m_tid);
      end
      @(negedge clk);
      s_tid   = 2'd1;
      s_tdata = 24'sd1000;
      for (int i = 0; i < 5; i++) begin
         @(posedge clk);
         #1;
         n_checks++;
         if (s_tready !== 1'b0 || m_tvalid !== 1'b1 || m_tdata !== 24'sd5000 || m_tid !== 2'd0) begin
            n_fail++;
            $display("FAIL bp_hold cycle=%0d: got ready=%0b valid=%0b data=%0d id=%0d, expected 0 1 5000 0",
                     i, s_tready, m_tvalid, m_tdata, m_tid);
         end
      end
      @(negedge clk);
      m_tready = 1'b1;
      @(posedge clk);
      #1;
      n_checks++;
      if (m_tid !== 2'd1 || m_tdata !== 24'sd1999) begin
         n_fail++;
         $display("FAIL bp_second: got data=%0d id=%0d, expected 1999 1", m_tdata, m_tid);
      end
      @(negedge clk);
      s_tid   = 2'd2;
      s_tdata = 24'sd32768;
      @(posedge clk);
      #1;
      s_tvalid = 1'b0;
      n_checks++;
      if (m_tid !== 2'd2 || m_tdata !== 24'sd64) begin
         n_fail++;
         $display("FAIL bp_third: got data=%0d id=%0d, expected 64 2", m_tdata, m_tid);
      end
      @(posedge clk);
      #1;
      n_checks++;
      if (m_tvalid !== 1'b0 || hs_q.size() != 3) begin
         n_fail++;
         $display("FAIL bp_count: got valid=%0b transfers=%0d, expected 0 3", m_tvalid, hs_q.size());
      end else begin
         n_checks++;
         if (hs_q[0] !== 2'd0 || hs_q[1] !== 2'd1 || hs_q[2] !== 2'd2) begin
            n_fail++;
            $display("FAIL bp_order: got %0d,%0d,%0d, expected 0,1,2", hs_q[0], hs_q[1], hs_q[2]);
         end
      end
   endtask

   task automatic test_edge_cases();
      logic signed [23:0] d;
      logic [1:0]         id;
      logic               ov;
      @(negedge clk);
      gain_valid = 1'b1;
      gain_ch    = 2'd3;
      gain_value = 16'd0;
      @(posedge clk);
      #1;
      gain_valid = 1'b0;
      for (int i = 0; i < 2; i++) begin
         xfer(2'd0, 24'sd5000, d, id, ov);
         n_checks++;
         if (d !== 24'sd5000) begin
            n_fail++;
            $display("FAIL edge_bad_gain_ch i=%0d: got %0d, expected 5000", i, d);
         end
      end
      xfer(2'd3, 24'sd12345, d, id, ov);
      n_checks++;
      if (d !== 24'sd0 || id !== 2'd3 || ov !== 1'b0) begin
         n_fail++;
         $display("FAIL edge_bad_tid: got data=%0d id=%0d ovf=%0b, expected 0 3 0", d, id, ov);
      end
      @(negedge clk);
      gain_valid = 1'b1;
      gain_ch    = 2'd0;
      gain_value = 16'd0;
      s_tvalid   = 1'b1;
      s_tid      = 2'd0;
      s_tdata    = 24'sd5000;
      @(posedge clk);
      #1;
      gain_valid = 1'b0;
      s_tvalid   = 1'b0;
      n_checks++;
      if (m_tdata !== 24'sd5000) begin
         n_fail++;
         $display("FAIL edge_same_cycle: got %0d, expected 5000", m_tdata);
      end
      xfer(2'd0, 24'sd5000, d, id, ov);
      n_checks++;
      if (d !== 24'sd5000) begin
         n_fail++;
         $display("FAIL edge_old_target_step: got %0d, expected 5000", d);
      end
      xfer(2'd0, 24'sd5000, d, id, ov);
      n_checks++;
      if (d !== 24'sd4990) begin
         n_fail++;
         $display("FAIL edge_new_target_step: got %0d, expected 4990", d);
      end
   endtask

   task automatic test_reset_midramp();
      logic signed [23:0] d;
      logic [1:0]         id;
      logic               ov;
      @(negedge clk);
      m_tready = 1'b0;
      s_tvalid = 1'b1;
      s_tid    = 2'd0;
      s_tdata  = 24'sd5000;
      @(posedge clk);
      #1;
      s_tvalid = 1'b0;
      n_checks++;
      if (m_tvalid !== 1'b1) begin
         n_fail++;
         $display("FAIL rstmid_pending: got valid=%0b, expected 1", m_tvalid);
      end
      #2;
      rst = 1'b1;
      #1;
      n_checks++;
      if (m_tvalid !== 1'b0 || m_tdata !== 24'sd0) begin
         n_fail++;
         $display("FAIL rstmid_async: got valid=%0b data=%0d, expected 0 0", m_tvalid, m_tdata);
      end
      @(posedge clk);
      @(negedge clk);
      rst      = 1'b0;
      m_tready = 1'b1;
      xfer(2'd0, 24'sd16384, d, id, ov);
      n_checks++;
      if (d !== 24'sd0) begin
         n_fail++;
         $display("FAIL rstmid_restart0: got %0d, expected 0", d);
      end
      xfer(2'd0, 24'sd16384, d, id, ov);
      n_checks++;
      if (d !== 24'sd32) begin
         n_fail++;
         $display("FAIL rstmid_restart1: got %0d, expected 32", d);
      end
   endtask

   initial begin
      test_reset();
      test_fade_in();
      test_overflow();
      test_mute();
      test_back_to_back();
      test_edge_cases();
      test_reset_midramp();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
